// File: rtl/branch_pc_unit.sv
// Program counter and condition unit: latches ALU flags, resolves conditional
// branches against the latched flags, and sequences IDLE/RUN/HALT.
module branch_pc_unit #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             flag_we,
    input  logic             z_in,
    input  logic             c_in,
    input  logic             n_in,
    input  logic             v_in,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    input  logic [OFF_W-1:0] br_off,
    input  logic             halt_req,
    output logic [PC_W-1:0]  pc,
    output logic [3:0]       flags,
    output logic             taken,
    output logic             running,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      flags_q, flags_d;
    logic            taken_q, taken_d;

    logic            cond_true;
    logic [PC_W-1:0] off_ext;

    // Offset is two's-complement; the add wraps modulo 2^PC_W naturally.
    assign off_ext = PC_W'($signed(br_off));

    // Conditions see the registered flags, never a same-edge flag_we update.
    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            3'b000: cond_true = 1'b1;
            3'b001: cond_true = flags_q[3];
            3'b010: cond_true = !flags_q[3];
            3'b011: cond_true = flags_q[1];
            3'b100: cond_true = !flags_q[1];
            3'b101: cond_true = !flags_q[3] && !flags_q[1];
            3'b110: cond_true = flags_q[2];
            3'b111: cond_true = flags_q[0];
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        taken_d = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    flags_d = '0;
                end
            end
            S_RUN: begin
                if (flag_we)
                    flags_d = {z_in, c_in, n_in, v_in};
                if (stall) begin
                    // hold pc and state; taken already defaults low
                end else if (halt_req) begin
                    state_d = S_HALT;
                end else if (br_valid && cond_true) begin
                    pc_d    = pc_q + off_ext;
                    taken_d = 1'b1;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            flags_q <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
            taken_q <= taken_d;
        end
    end

    assign pc      = pc_q;
    assign flags   = flags_q;
    assign taken   = taken_q;
    assign running = (state_q == S_RUN);
    assign done    = (state_q == S_HALT);

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed self-checking bench for branch_pc_unit; every observation is the
// packed vector {pc, flags, taken, running, done} against a hand-derived value.
module tb_branch_pc_unit;

    logic       clk = 1'b0;
    logic       reset, start, stall, flag_we;
    logic       z_in, c_in, n_in, v_in;
    logic       br_valid, halt_req;
    logic [2:0] br_cond;
    logic [7:0] br_off;
    logic [9:0] pc;
    logic [3:0] flags;
    logic       taken, running, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] obs, exp_v;
    assign obs = {pc, flags, taken, running, done};

    always #5 clk = ~clk;

    branch_pc_unit #(.PC_W(10), .OFF_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .flag_we(flag_we), .z_in(z_in), .c_in(c_in), .n_in(n_in), .v_in(v_in),
        .br_valid(br_valid), .br_cond(br_cond), .br_off(br_off),
        .halt_req(halt_req), .pc(pc), .flags(flags), .taken(taken),
        .running(running), .done(done)
    );

    function automatic logic [16:0] mk(input logic [9:0] p, input logic [3:0] f,
                                       input logic t, input logic r, input logic d);
        return {p, f, t, r, d};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; stall = 0; flag_we = 0;
        {z_in, c_in, n_in, v_in} = 4'b0000;
        br_valid = 0; br_cond = 3'b000; br_off = 8'h00; halt_req = 0;
    endtask

    task automatic restart();
        idle_inputs();
        reset = 1; step();
        reset = 0; start = 1; step();
        start = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; step(); step();
        exp_v = mk(10'd0, 4'b0000, 0, 0, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
        // IDLE ignores everything but start
        reset = 0; br_valid = 1; br_off = 8'd5; flag_we = 1; z_in = 1;
        step();
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL idle_ignore: got %h want %h", obs, exp_v); end
        idle_inputs(); start = 1; step(); start = 0;
        exp_v = mk(10'd0, 4'b0000, 0, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL start: got %h want %h", obs, exp_v); end
        for (int i = 1; i <= 5; i++) begin
            step();
            exp_v = mk(10'(i), 4'b0000, 0, 1, 0);
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL incr[%0d]: got %h want %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_compare_branch();
        restart();
        repeat (4) step();
        flag_we = 1; z_in = 1; n_in = 0; step();
        flag_we = 0; z_in = 0;
        exp_v = mk(10'd5, 4'b1000, 0, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL cmp_flags: got %h want %h", obs, exp_v); end
        br_valid = 1; br_cond = 3'b001; br_off = 8'hFC; step();
        br_valid = 0;
        exp_v = mk(10'd1, 4'b1000, 1, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL beq_taken: got %h want %h", obs, exp_v); end
        step();
        exp_v = mk(10'd2, 4'b1000, 0, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL taken_pulse: got %h want %h", obs, exp_v); end
        step(); step();
        flag_we = 1; z_in = 1; step();
        flag_we = 0; z_in = 0;
        br_valid = 1; br_cond = 3'b010; br_off = 8'hFC; step();
        br_valid = 0;
        exp_v = mk(10'd6, 4'b1000, 0, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL bne_not_taken: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_same_edge_hazard();
        restart();
        flag_we = 1; z_in = 1; br_valid = 1; br_cond = 3'b001; br_off = 8'd5;
        step();
        flag_we = 0; z_in = 0;
        exp_v = mk(10'd1, 4'b1000, 0, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL same_edge: got %h want %h", obs, exp_v); end
        step();
        br_valid = 0;
        exp_v = mk(10'd6, 4'b1000, 1, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL next_edge_use: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_cond_codes();
        // {flags zcnv, cond, expected taken}
        logic [7:0] tbl [16] = '{
            8'b0000_000_1, 8'b1000_001_1, 8'b0000_001_0, 8'b0000_010_1,
            8'b1000_010_0, 8'b0010_011_1, 8'b0000_011_0, 8'b0010_100_0,
            8'b0000_100_1, 8'b0000_101_1, 8'b1000_101_0, 8'b0010_101_0,
            8'b0100_110_1, 8'b0000_110_0, 8'b0001_111_1, 8'b1110_111_0};
        for (int i = 0; i < 16; i++) begin
            restart();
            flag_we = 1; {z_in, c_in, n_in, v_in} = tbl[i][7:4]; step();
            flag_we = 0; {z_in, c_in, n_in, v_in} = 4'b0000;
            br_valid = 1; br_cond = tbl[i][3:1]; br_off = 8'd3; step();
            br_valid = 0;
            exp_v = mk(tbl[i][0] ? 10'd4 : 10'd2, tbl[i][7:4], tbl[i][0], 1, 0);
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL cond[%0d]: got %h want %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_wrap_stall();
        restart();
        br_valid = 1; br_cond = 3'b000; br_off = 8'hFF; step();
        br_valid = 0;
        exp_v = mk(10'd1023, 4'b0000, 1, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL neg_cross0: got %h want %h", obs, exp_v); end
        step();
        exp_v = mk(10'd0, 4'b0000, 0, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL pc_wrap: got %h want %h", obs, exp_v); end
        repeat (5) step();
        stall = 1; br_valid = 1; br_cond = 3'b000; br_off = 8'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = mk(10'd5, 4'b0000, 0, 1, 0);
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL stall[%0d]: got %h want %h", i, obs, exp_v); end
        end
        stall = 0; step();
        exp_v = mk(10'd8, 4'b0000, 1, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL post_stall_br: got %h want %h", obs, exp_v); end
        stall = 1; step();
        exp_v = mk(10'd8, 4'b0000, 0, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL stall_kills_pulse: got %h want %h", obs, exp_v); end
        stall = 0; br_off = 8'd0;
        for (int i = 0; i < 2; i++) begin
            step();
            exp_v = mk(10'd8, 4'b0000, 1, 1, 0);
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL self_loop[%0d]: got %h want %h", i, obs, exp_v); end
        end
        br_off = 8'h80; step();
        br_valid = 0;
        exp_v = mk(10'd904, 4'b0000, 1, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL off_min: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_halt_restart();
        restart();
        flag_we = 1; {z_in, c_in, n_in, v_in} = 4'b1111; step();
        flag_we = 0; {z_in, c_in, n_in, v_in} = 4'b0000;
        repeat (6) step();
        stall = 1; halt_req = 1; step();
        exp_v = mk(10'd7, 4'b1111, 0, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL stall_over_halt: got %h want %h", obs, exp_v); end
        stall = 0; br_valid = 1; br_cond = 3'b000; br_off = 8'd3; step();
        halt_req = 0;
        exp_v = mk(10'd7, 4'b1111, 0, 0, 1);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL halt: got %h want %h", obs, exp_v); end
        flag_we = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL halt_frozen[%0d]: got %h want %h", i, obs, exp_v); end
        end
        flag_we = 0; br_valid = 0; start = 1; step();
        start = 0;
        exp_v = mk(10'd0, 4'b0000, 0, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL halt_restart: got %h want %h", obs, exp_v); end
        step();
        exp_v = mk(10'd1, 4'b0000, 0, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL restart_incr: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid_branch();
        restart();
        br_valid = 1; br_cond = 3'b000; br_off = 8'd20;
        flag_we = 1; {z_in, c_in, n_in, v_in} = 4'b1111; step();
        exp_v = mk(10'd20, 4'b1111, 1, 1, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reach_20: got %h want %h", obs, exp_v); end
        br_off = 8'd10; reset = 1; step();
        exp_v = mk(10'd0, 4'b0000, 0, 0, 0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_mid_br: got %h want %h", obs, exp_v); end
        idle_inputs(); step();
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL stays_idle: got %h want %h", obs, exp_v); end
    endtask

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_compare_branch();
        test_same_edge_hazard();
        test_cond_codes();
        test_wrap_stall();
        test_halt_restart();
        test_reset_mid_branch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
